// File: rtl/pipe_sel_reg_pkg.sv
// Shared constants, parameter bounds and helpers for the selectable register pipe.
package pipe_sel_reg_pkg;

    localparam int unsigned WIDTH_DEFAULT = 32;
    localparam int unsigned NUM_IN_MIN    = 2;
    localparam int unsigned NUM_IN_MAX    = 8;
    localparam int unsigned DEPTH_MIN     = 1;
    localparam int unsigned DEPTH_MAX     = 4;

    // Flags that travel alongside the data word through every stage.
    typedef struct packed {
        logic valid;
        logic err;
    } stage_flags_t;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    // Select width, never narrower than one bit.
    function automatic int unsigned sel_width(input int unsigned n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage holding data, valid and err with hold, clear and async reset.
module pipe_stage_reg
    import pipe_sel_reg_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold,
    input  logic             clear,
    input  logic [WIDTH-1:0] d_data,
    input  stage_flags_t     d_flags,
    output logic [WIDTH-1:0] q_data,
    output stage_flags_t     q_flags
);

    // Clear wins over hold; otherwise capture unless held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_data  <= '0;
            q_flags <= '0;
        end else if (clear) begin
            q_data  <= '0;
            q_flags <= '0;
        end else if (!hold) begin
            q_data  <= d_data;
            q_flags <= d_flags;
        end
    end

endmodule

// File: rtl/pipe_sel_reg.sv
// N:1 input select followed by a DEPTH-stage register pipe with stall and flush.
module pipe_sel_reg
    import pipe_sel_reg_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_DEFAULT,
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned DEPTH  = 1,
    localparam int unsigned SEL_W = sel_width(NUM_IN)
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic [NUM_IN*WIDTH-1:0] In_Bus,
    input  logic [SEL_W-1:0]        Select,
    input  logic                    In_Valid,
    input  logic                    Stall,
    input  logic                    Flush,
    output logic [WIDTH-1:0]        Out,
    output logic                    Out_Valid,
    output logic                    Sel_Err
);

    // Reject illegal parameterisations at elaboration.
    generate
        if (NUM_IN < NUM_IN_MIN || NUM_IN > NUM_IN_MAX) begin : g_bad_num_in
            $error("pipe_sel_reg: NUM_IN out of legal range");
        end
        if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
            $error("pipe_sel_reg: DEPTH out of legal range");
        end
    endgenerate

    logic [WIDTH-1:0] chain_data  [DEPTH+1];
    stage_flags_t     chain_flags [DEPTH+1];

    logic [WIDTH-1:0] sel_data_c;
    logic             in_range_c;

    // Front end: pick input[Select], fall back to input 0 when out of range.
    always_comb begin
        sel_data_c = In_Bus[WIDTH-1:0];
        in_range_c = 1'b0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (Select == SEL_W'(k)) begin
                sel_data_c = In_Bus[k*WIDTH +: WIDTH];
                in_range_c = 1'b1;
            end
        end
    end

    // Invalid cycles enter the pipe as all-zero bubbles.
    assign chain_data[0]        = In_Valid ? sel_data_c : '0;
    assign chain_flags[0].valid = In_Valid;
    assign chain_flags[0].err   = In_Valid & ~in_range_c;

    generate
        for (genvar i = 0; i < int'(DEPTH); i++) begin : g_stage
            pipe_stage_reg #(
                .WIDTH(WIDTH)
            ) u_stage (
                .clk    (Clk),
                .rst_n  (Reset_n),
                .hold   (Stall),
                .clear  (Flush),
                .d_data (chain_data[i]),
                .d_flags(chain_flags[i]),
                .q_data (chain_data[i+1]),
                .q_flags(chain_flags[i+1])
            );
        end
    endgenerate

    assign Out       = chain_data[DEPTH];
    assign Out_Valid = chain_flags[DEPTH].valid;
    assign Sel_Err   = chain_flags[DEPTH].err;

endmodule

// File: tb/tb_pipe_sel_reg.sv
// Bench for pipe_sel_reg: two instances (4 inputs/depth 2 and 3 inputs/depth 3)
// checked against a delay-line reference model, vector tables and hand sequences.
module tb_pipe_sel_reg;

    localparam int unsigned DA = 2;
    localparam int unsigned DB = 3;

    logic         Clk;
    logic         Reset_n;
    logic [127:0] In_Bus_a;
    logic [95:0]  In_Bus_b;
    logic [1:0]   Select;
    logic         In_Valid;
    logic         Stall;
    logic         Flush;
    logic [31:0]  out_a, out_b;
    logic         ov_a, ov_b, err_a, err_b;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] data;
        logic        valid;
        logic        err;
    } ent_t;

    ent_t qa[$];
    ent_t qb[$];

    assign In_Bus_b = In_Bus_a[95:0];

    pipe_sel_reg #(.WIDTH(32), .NUM_IN(4), .DEPTH(DA)) dut_a (
        .Clk(Clk), .Reset_n(Reset_n), .In_Bus(In_Bus_a), .Select(Select),
        .In_Valid(In_Valid), .Stall(Stall), .Flush(Flush),
        .Out(out_a), .Out_Valid(ov_a), .Sel_Err(err_a)
    );

    pipe_sel_reg #(.WIDTH(32), .NUM_IN(3), .DEPTH(DB)) dut_b (
        .Clk(Clk), .Reset_n(Reset_n), .In_Bus(In_Bus_b), .Select(Select),
        .In_Valid(In_Valid), .Stall(Stall), .Flush(Flush),
        .Out(out_b), .Out_Valid(ov_b), .Sel_Err(err_b)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // What enters the pipe this cycle, straight from the selection rules.
    function automatic ent_t entry_of(input logic [127:0] bus, input int n,
                                      input logic [1:0] sel, input logic v);
        ent_t e;
        int   idx;
        e = '0;
        if (v) begin
            idx     = (int'(sel) < n) ? int'(sel) : 0;
            e.data  = bus[idx*32 +: 32];
            e.valid = 1'b1;
            e.err   = (int'(sel) >= n);
        end
        return e;
    endfunction

    // Output = entry captured DEPTH advances ago since the last clear, else zeros.
    function automatic ent_t expect_of(input ent_t q[$], input int d);
        if (q.size() < d) return '0;
        return q[q.size() - d];
    endfunction

    task automatic model_clear();
        qa.delete();
        qb.delete();
    endtask

    task automatic model_edge();
        if (!Reset_n || Flush) begin
            model_clear();
        end else if (!Stall) begin
            qa.push_back(entry_of(In_Bus_a, 4, Select, In_Valid));
            qb.push_back(entry_of({32'h0, In_Bus_b}, 3, Select, In_Valid));
            if (qa.size() > DA) void'(qa.pop_front());
            if (qb.size() > DB) void'(qb.pop_front());
        end
    endtask

    task automatic check_model();
        ent_t ea, eb;
        ea = expect_of(qa, DA);
        eb = expect_of(qb, DB);
        chk("model_out_a",   out_a,        ea.data);
        chk("model_valid_a", 32'(ov_a),    32'(ea.valid));
        chk("model_err_a",   32'(err_a),   32'(ea.err));
        chk("model_out_b",   out_b,        eb.data);
        chk("model_valid_b", 32'(ov_b),    32'(eb.valid));
        chk("model_err_b",   32'(err_b),   32'(eb.err));
    endtask

    // One clock: model follows the edge, outputs sampled 1 time unit later.
    task automatic step();
        @(posedge Clk);
        model_edge();
        #1;
        check_model();
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic        valid;
        logic [31:0] exp_out;
        logic        exp_valid;
    } vec_t;

    vec_t vecs[11];

    int          exp_stall[10];
    int          val_stall[10];
    logic        stall_pat[10];

    initial begin
        // Select sweep then a 1,0,1 bubble pattern on the 4-input, depth-2 instance.
        vecs[0]  = '{2'd0, 1'b1, 32'h00, 1'b0};
        vecs[1]  = '{2'd1, 1'b1, 32'h11, 1'b1};
        vecs[2]  = '{2'd2, 1'b1, 32'h22, 1'b1};
        vecs[3]  = '{2'd3, 1'b1, 32'h33, 1'b1};
        vecs[4]  = '{2'd0, 1'b0, 32'h44, 1'b1};
        vecs[5]  = '{2'd0, 1'b0, 32'h00, 1'b0};
        vecs[6]  = '{2'd0, 1'b1, 32'h00, 1'b0};
        vecs[7]  = '{2'd0, 1'b0, 32'h11, 1'b1};
        vecs[8]  = '{2'd0, 1'b1, 32'h00, 1'b0};
        vecs[9]  = '{2'd0, 1'b0, 32'h11, 1'b1};
        vecs[10] = '{2'd0, 1'b0, 32'h00, 1'b0};

        val_stall = '{1, 2, 3, 4, 99, 99, 5, 6, 7, 8};
        stall_pat = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
        exp_stall = '{0, 0, 1, 2, 2, 2, 3, 4, 5, 6};

        Reset_n  = 1'b0;
        In_Bus_a = '0;
        Select   = '0;
        In_Valid = 1'b0;
        Stall    = 1'b0;
        Flush    = 1'b0;

        // Reset state, with active-looking inputs that must be ignored.
        #2;
        In_Valid = 1'b1;
        In_Bus_a = {32'hDEAD, 32'hBEEF, 32'hCAFE, 32'hF00D};
        repeat (3) step();
        chk("reset_out_a",   out_a,      32'h0);
        chk("reset_valid_b", 32'(ov_b),  32'h0);
        Reset_n  = 1'b1;
        In_Valid = 1'b0;

        // Table-driven sweep and bubbles.
        In_Bus_a = {32'h44, 32'h33, 32'h22, 32'h11};
        for (int i = 0; i < 11; i++) begin
            Select   = vecs[i].sel;
            In_Valid = vecs[i].valid;
            step();
            chk($sformatf("vec%0d_out", i),   out_a,     vecs[i].exp_out);
            chk($sformatf("vec%0d_valid", i), 32'(ov_a), 32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_err", i),   32'(err_a), 32'h0);
        end

        // Out-of-range select on the 3-input instance falls back to input 0 with err.
        Flush = 1'b1; In_Valid = 1'b0;
        step();
        Flush = 1'b0;
        In_Bus_a = {32'hDDDD, 32'hCCCC, 32'hBBBB, 32'hAAAA0000};
        Select   = 2'd3;
        In_Valid = 1'b1;
        step();
        In_Valid = 1'b0;
        step();
        chk("oor_a_out",   out_a,      32'hDDDD);
        chk("oor_a_err",   32'(err_a), 32'h0);
        chk("oor_a_valid", 32'(ov_a),  32'h1);
        step();
        chk("oor_b_out",   out_b,      32'hAAAA0000);
        chk("oor_b_err",   32'(err_b), 32'h1);
        chk("oor_b_valid", 32'(ov_b),  32'h1);

        // Stall for two cycles mid-stream on the depth-3 instance.
        Flush = 1'b1;
        step();
        Flush  = 1'b0;
        Select = 2'd0;
        for (int i = 0; i < 10; i++) begin
            In_Bus_a = {96'h0, 32'(val_stall[i])};
            In_Valid = 1'b1;
            Stall    = stall_pat[i];
            step();
            if (i >= 2) begin
                chk($sformatf("stall_out%0d", i),   out_b,     32'(exp_stall[i]));
                chk($sformatf("stall_valid%0d", i), 32'(ov_b), 32'h1);
            end
        end

        // Flush together with stall on a full pipe.
        Stall = 1'b1; Flush = 1'b1;
        step();
        chk("flush_out_a",   out_a,      32'h0);
        chk("flush_valid_a", 32'(ov_a),  32'h0);
        chk("flush_err_b",   32'(err_b), 32'h0);
        chk("flush_valid_b", 32'(ov_b),  32'h0);
        Stall = 1'b0; Flush = 1'b0;
        In_Bus_a = {96'h0, 32'h55};
        step();
        chk("post_flush1_valid_a", 32'(ov_a), 32'h0);
        In_Valid = 1'b0;
        step();
        chk("post_flush2_out_a",   out_a,     32'h55);
        chk("post_flush2_valid_a", 32'(ov_a), 32'h1);

        // Asynchronous reset between edges while output is valid.
        In_Bus_a = {96'h0, 32'h77};
        In_Valid = 1'b1;
        step();
        step();
        chk("pre_rst_valid_a", 32'(ov_a), 32'h1);
        #2 Reset_n = 1'b0;
        model_clear();
        #1;
        chk("async_rst_out_a",   out_a,      32'h0);
        chk("async_rst_valid_a", 32'(ov_a),  32'h0);
        chk("async_rst_valid_b", 32'(ov_b),  32'h0);
        chk("async_rst_err_b",   32'(err_b), 32'h0);
        #1 Reset_n = 1'b1;
        In_Bus_a = {96'h0, 32'h66};
        step();
        chk("post_rst1_valid_a", 32'(ov_a), 32'h0);
        In_Valid = 1'b0;
        step();
        chk("post_rst2_out_a",   out_a,     32'h66);
        chk("post_rst2_valid_a", 32'(ov_a), 32'h1);

        // Randomised traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            In_Bus_a = {$urandom, $urandom, $urandom, $urandom};
            Select   = 2'($urandom_range(0, 3));
            In_Valid = ($urandom_range(0, 3) != 0);
            Stall    = ($urandom_range(0, 6) == 0);
            Flush    = ($urandom_range(0, 19) == 0);
            step();
            if ($urandom_range(0, 99) == 0) begin
                #2 Reset_n = 1'b0;
                model_clear();
                #1 check_model();
                #1 Reset_n = 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_sel_reg.md
PIPE_SEL_REG -- requirements
Module: pipe_sel_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width of each input and of the output.
REQ-002 SHALL have parameter NUM_IN, default 4, legal range 2..8: number of selectable inputs.
REQ-003 SHALL have parameter DEPTH, default 1, legal range 1..4: number of register stages, which equals the latency.
REQ-004 SHALL derive SEL_W = clog2(NUM_IN), with a minimum of 1.
REQ-005 SHALL have port Clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-006 SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port In_Bus, input, NUM_IN*WIDTH bits: input k occupies bits [k*WIDTH+WIDTH-1 : k*WIDTH].
REQ-008 SHALL have port Select, input, SEL_W bits: index of the input to capture.
REQ-009 SHALL have port In_Valid, input, 1 bit: qualifies In_Bus and Select this cycle.
REQ-010 SHALL have port Stall, input, 1 bit: freezes every stage.
REQ-011 SHALL have port Flush, input, 1 bit: invalidates every stage.
REQ-012 SHALL have port Out, output, WIDTH bits: data from the last stage.
REQ-013 SHALL have port Out_Valid, output, 1 bit: valid flag of the last stage.
REQ-014 SHALL have port Sel_Err, output, 1 bit: error flag travelling with the data; set when Select >= NUM_IN.

Function
REQ-015 Selection rule: stage-0 next data SHALL be input[Select] when Select < NUM_IN, and input 0 otherwise.
REQ-016 An out-of-range Select SHALL set the stage-0 error bit, but only when In_Valid=1.
REQ-017 Each stage SHALL hold three fields: data (WIDTH bits), valid (1 bit) and err (1 bit).
REQ-018 Normal advance (Stall=0, Flush=0):
  - stage 0 SHALL capture {selected data, In_Valid, error bit};
  - stage i SHALL capture stage i-1;
  - latency from input to Out SHALL be exactly DEPTH cycles.
REQ-019 Stall=1 with Flush=0: every stage SHALL hold its contents, and the inputs of that cycle SHALL be discarded.
REQ-020 Flush=1: every stage SHALL load data=0, valid=0, err=0 on that edge.
REQ-021 Flush SHALL take priority over Stall, so Flush=1 with Stall=1 behaves as a flush.
REQ-022 When In_Valid=0 during an advance, the stage SHALL load a bubble: valid=0, err=0, data=0.
REQ-023 Outputs SHALL be direct register outputs, with no combinational path from inputs to outputs.
REQ-024 Sel_Err SHALL be meaningful only while Out_Valid=1, and SHALL be 0 whenever Out_Valid=0.
REQ-025 When DEPTH=1, the block SHALL behave as a single registered N:1 mux with stall and flush.
REQ-026 Parameter values outside their legal range SHALL raise an elaboration-time error.

Reset
REQ-027 Reset_n=0 SHALL immediately and asynchronously clear every stage to data=0, valid=0, err=0, independent of Clk.
REQ-028 While in reset: Out=0, Out_Valid=0, Sel_Err=0.
REQ-029 Reset asserted mid-stream SHALL discard all in-flight entries, with no partial state retained.
REQ-030 The first capture after release SHALL occur on the first rising Clk edge with Reset_n=1.

Structure
REQ-031 The shared constants include file SHALL hold:
  - the default WIDTH of 32;
  - the legal-range bounds for NUM_IN and DEPTH;
  - a clog2 helper function.
REQ-032 One sub-module, pipe_stage_reg, SHALL implement a single stage (data, valid, err) with hold, clear and async reset.
REQ-033 The top level SHALL contain a generate loop over DEPTH instances of pipe_stage_reg plus the combinational selection front end.

Verification
REQ-034 Select sweep: WIDTH=32, NUM_IN=4, DEPTH=2; In_Bus={0x44,0x33,0x22,0x11}; Select=0..3 on consecutive cycles, all valid -> Out = 0x11, 0x22, 0x33, 0x44 starting 2 cycles later, with Out_Valid=1 throughout.
REQ-035 Out-of-range select: NUM_IN=3, Select=3, In_Valid=1 -> after DEPTH cycles, Out = input 0, Sel_Err=1, Out_Valid=1.
REQ-036 Stall: DEPTH=3, stream values 1,2,3,4, then Stall=1 for 2 cycles -> Out holds its value for 2 cycles; the sequence then resumes with no loss and no duplication.
REQ-037 Flush with stall: full pipe, Flush=1 and Stall=1 together -> on the next edge Out_Valid=0, Out=0, Sel_Err=0; new data appears DEPTH cycles after Flush deasserts.
REQ-038 Async reset: Reset_n pulled low between clock edges while Out_Valid=1 -> outputs clear before the next edge; after release, the first valid appears DEPTH cycles after the first capture.
REQ-039 Bubble handling: In_Valid pattern 1,0,1 with Select=0 -> Out_Valid pattern 1,0,1 delayed by DEPTH cycles, and Out=0 during the bubble.
